// File: rtl/sprite_cmd_if.sv
// Avalon-MM slave port, VGA counters and sprite command bus of the dispatcher.
interface sprite_cmd_if;
   logic        chipselect;
   logic        write;
   logic        read;
   logic        address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic [31:0] cmd_data;
   logic        cmd_valid;

   modport slave (
      input  chipselect, write, read, address, writedata, hcount, vcount,
      output readdata, cmd_data, cmd_valid
   );

   modport master (
      output chipselect, write, read, address, writedata, hcount, vcount,
      input  readdata, cmd_data, cmd_valid
   );
endinterface

// File: rtl/sprite_cmd_dispatcher.sv
// Queues CPU sprite commands and replays a committed batch during vertical blank,
// then broadcasts a buffer toggle to every sprite component.
module sprite_cmd_dispatcher #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned N_COMPONENTS = 9,
   parameter int unsigned V_ACTIVE     = 480
) (
   input  logic        clk,
   input  logic        reset,
   sprite_cmd_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ID_W  = 6;

   typedef enum logic [1:0] {IDLE, DRAIN, TOGGLE} state_t;

   state_t            state, state_nxt;
   logic [31:0]       mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count, count_nxt;
   logic [CNT_W-1:0]  batch_len, batch_len_nxt;
   logic [ID_W-1:0]   tog_id, tog_id_nxt, id_c;
   logic              front, front_nxt;
   logic              commit_pending, commit_pending_nxt;
   logic              overflow, overflow_nxt;
   logic              commit_err, commit_err_nxt;
   logic [9:0]        prev_vcount;
   logic [31:0]       readdata, readdata_nxt;
   logic [31:0]       cmd_data, cmd_data_nxt;
   logic              cmd_valid, cmd_valid_nxt;

   logic              cmd_wr_c, commit_wr_c, status_rd_c;
   logic              full_c, push_c, pop_c, vblank_edge_c, drain_phase_c;
   logic [31:0]       head_c;
   logic              unused_hcount;

   assign cmd_wr_c      = bus.chipselect & bus.write & ~bus.address;
   assign commit_wr_c   = bus.chipselect & bus.write &  bus.address;
   assign status_rd_c   = bus.chipselect & bus.read  &  bus.address;
   assign full_c        = (count == CNT_W'(DEPTH));
   assign push_c        = cmd_wr_c & ~full_c;
   assign head_c        = mem[rd_ptr];
   assign vblank_edge_c = (bus.vcount == 10'(V_ACTIVE)) && (prev_vcount != 10'(V_ACTIVE));
   // Entering from IDLE behaves like a DRAIN cycle so the first word leaves on the edge cycle.
   assign drain_phase_c = (state == DRAIN) ||
                          ((state == IDLE) && vblank_edge_c && commit_pending);
   assign id_c          = (state == TOGGLE) ? tog_id : ID_W'(1);
   assign unused_hcount = ^bus.hcount;

   assign bus.readdata  = readdata;
   assign bus.cmd_data  = cmd_data;
   assign bus.cmd_valid = cmd_valid;

   // Next-state, flag and registered-output logic.
   always_comb begin
      state_nxt          = state;
      batch_len_nxt      = batch_len;
      tog_id_nxt         = tog_id;
      front_nxt          = front;
      commit_pending_nxt = commit_pending;
      overflow_nxt       = overflow;
      commit_err_nxt     = commit_err;
      cmd_data_nxt       = '0;
      cmd_valid_nxt      = 1'b0;
      pop_c              = 1'b0;

      if (drain_phase_c && (batch_len != '0)) begin
         pop_c         = 1'b1;
         cmd_valid_nxt = 1'b1;
         cmd_data_nxt  = {head_c[31:14], ~front, head_c[12:0]};
         batch_len_nxt = batch_len - CNT_W'(1);
         tog_id_nxt    = ID_W'(1);
         state_nxt     = (batch_len == CNT_W'(1)) ? TOGGLE : DRAIN;
      end else if (drain_phase_c || (state == TOGGLE)) begin
         cmd_valid_nxt = 1'b1;
         cmd_data_nxt  = {id_c, 5'd0, 4'b1111, 3'b000, ~front, 13'd0};
         if (id_c == ID_W'(N_COMPONENTS)) begin
            state_nxt          = IDLE;
            front_nxt          = ~front;
            commit_pending_nxt = 1'b0;
         end else begin
            state_nxt  = TOGGLE;
            tog_id_nxt = id_c + ID_W'(1);
         end
      end

      // Clear-on-read first so an event in the same cycle is not lost.
      if (status_rd_c) begin
         overflow_nxt   = 1'b0;
         commit_err_nxt = 1'b0;
      end
      if (cmd_wr_c && full_c) overflow_nxt = 1'b1;

      if (commit_wr_c) begin
         if (!commit_pending) begin
            batch_len_nxt      = count;
            commit_pending_nxt = 1'b1;
         end else begin
            commit_err_nxt = 1'b1;
         end
      end

      count_nxt    = count + CNT_W'(push_c) - CNT_W'(pop_c);
      readdata_nxt = status_rd_c ?
                     {19'd0, commit_err, overflow, front, commit_pending, full_c, 3'd0, 5'(count)} :
                     32'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         batch_len      <= '0;
         tog_id         <= '0;
         front          <= 1'b0;
         commit_pending <= 1'b0;
         overflow       <= 1'b0;
         commit_err     <= 1'b0;
         prev_vcount    <= '0;
         readdata       <= '0;
         cmd_data       <= '0;
         cmd_valid      <= 1'b0;
      end else begin
         state          <= state_nxt;
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         count          <= count_nxt;
         batch_len      <= batch_len_nxt;
         tog_id         <= tog_id_nxt;
         front          <= front_nxt;
         commit_pending <= commit_pending_nxt;
         overflow       <= overflow_nxt;
         commit_err     <= commit_err_nxt;
         prev_vcount    <= bus.vcount;
         readdata       <= readdata_nxt;
         cmd_data       <= cmd_data_nxt;
         cmd_valid      <= cmd_valid_nxt;
      end
   end

   // Storage carries no reset; emptiness is tracked by count.
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= bus.writedata;
   end

endmodule

// File: tb/tb_sprite_cmd_dispatcher.sv
// Directed bench for sprite_cmd_dispatcher: commands, commits, vblank dispatch and status.
module tb_sprite_cmd_dispatcher;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   logic [31:0] exp_w[$];
   logic [31:0] rd;
   logic [31:0] wa, wb, wc, wd, we;

   sprite_cmd_if bus ();

   sprite_cmd_dispatcher dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic av_write(input logic addr, input logic [31:0] data);
      bus.chipselect = 1'b1;
      bus.write      = 1'b1;
      bus.address    = addr;
      bus.writedata  = data;
      tick();
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
      bus.address    = 1'b0;
      bus.writedata  = '0;
   endtask

   task automatic status_read(input logic addr, output logic [31:0] data);
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = addr;
      tick();
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      bus.address    = 1'b0;
      data = bus.readdata;
   endtask

   task automatic set_vcount(input int v);
      bus.vcount = 10'(v);
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [31:0] sprite_word(input int t, input int data);
      return {6'd9, 5'd0, 4'd1, 3'(t), 1'b0, 13'(data)};
   endfunction

   // Raise vcount to 480 and check exp_w words then 9 toggle words; optional reset at a toggle id.
   task automatic run_vblank(input logic nb, input int abort_id);
      int n;
      logic [31:0] w;
      logic [31:0] e;
      n = exp_w.size();
      bus.vcount = 10'd480;
      for (int i = 0; i < n + 9; i++) begin
         tick();
         if (i < n) begin
            w = exp_w[i];
            e = {w[31:14], nb, w[12:0]};
         end else begin
            e = {6'(i - n + 1), 5'd0, 4'b1111, 3'b000, nb, 13'd0};
         end
         check_eq($sformatf("dispatch_word_%0d", i), bus.cmd_data, e);
         check_eq($sformatf("dispatch_valid_%0d", i), 32'(bus.cmd_valid), 32'd1);
         if ((i >= n) && (i - n + 1 == abort_id)) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check_eq("abort_valid", 32'(bus.cmd_valid), 32'd0);
            check_eq("abort_data", bus.cmd_data, 32'd0);
            return;
         end
      end
      tick();
      check_eq("after_dispatch_valid", 32'(bus.cmd_valid), 32'd0);
   endtask

   initial begin
      int nvalid;
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
      bus.read       = 1'b0;
      bus.address    = 1'b0;
      bus.writedata  = '0;
      bus.hcount     = '0;
      bus.vcount     = '0;
      tick();
      tick();
      check_eq("reset_valid", 32'(bus.cmd_valid), 32'd0);
      check_eq("reset_data", bus.cmd_data, 32'd0);
      check_eq("reset_readdata", bus.readdata, 32'd0);
      reset = 1'b0;

      // Reset status and a full idle frame
      status_read(1'b1, rd);
      check_eq("reset_status", rd, 32'd0);
      nvalid = 0;
      for (int v = 0; v < 525; v++) begin
         bus.vcount = 10'(v);
         tick();
         if (bus.cmd_valid) nvalid++;
      end
      check_eq("idle_frame_valid_cycles", 32'(nvalid), 32'd0);
      set_vcount(0);

      // Three-word batch
      exp_w.delete();
      for (int t = 1; t <= 3; t++) begin
         exp_w.push_back(sprite_word(t, 16 * t + 5));
         av_write(1'b0, sprite_word(t, 16 * t + 5));
      end
      status_read(1'b0, rd);
      check_eq("addr0_read_zero", rd, 32'd0);
      av_write(1'b1, 32'd0);
      run_vblank(1'b1, 0);
      set_vcount(0);
      status_read(1'b1, rd);
      check_eq("status_after_batch", rd, 32'h0000_0400);

      // Overflow with 17 pushes
      for (int i = 0; i < 17; i++) av_write(1'b0, 32'(i));
      status_read(1'b1, rd);
      check_eq("status_overflow", rd, 32'h0000_0D10);
      status_read(1'b1, rd);
      check_eq("status_overflow_cleared", rd, 32'h0000_0510);
      do_reset();
      status_read(1'b1, rd);
      check_eq("status_after_reset", rd, 32'd0);

      // Double commit: only the first batch (A) goes out, B stays queued
      wa = sprite_word(4, 13'h1abc);
      wb = sprite_word(5, 13'h0123);
      av_write(1'b0, wa);
      av_write(1'b1, 32'd0);
      av_write(1'b0, wb);
      av_write(1'b1, 32'd0);
      status_read(1'b1, rd);
      check_eq("status_commit_err", rd, 32'h0000_1202);
      exp_w.delete();
      exp_w.push_back(wa);
      run_vblank(1'b1, 0);
      set_vcount(0);
      status_read(1'b1, rd);
      check_eq("status_after_first_batch", rd, 32'h0000_0401);

      // Commit after the edge waits for the next 479->480 transition
      set_vcount(480);
      set_vcount(481);
      av_write(1'b1, 32'd0);
      nvalid = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.cmd_valid) nvalid++;
      end
      check_eq("late_commit_no_dispatch", 32'(nvalid), 32'd0);
      set_vcount(479);
      exp_w.delete();
      exp_w.push_back(wb);
      run_vblank(1'b0, 0);
      set_vcount(0);
      status_read(1'b1, rd);
      check_eq("status_after_late_batch", rd, 32'h0000_0000);

      // Push after commit stays queued; then reset mid-toggle
      wc = sprite_word(6, 13'h0fff);
      wd = sprite_word(7, 13'h1000);
      we = sprite_word(1, 13'h0042);
      av_write(1'b0, wc);
      av_write(1'b0, wd);
      av_write(1'b1, 32'd0);
      av_write(1'b0, we);
      exp_w.delete();
      exp_w.push_back(wc);
      exp_w.push_back(wd);
      run_vblank(1'b1, 0);
      set_vcount(0);
      status_read(1'b1, rd);
      check_eq("status_one_left", rd, 32'h0000_0401);
      av_write(1'b1, 32'd0);
      exp_w.delete();
      exp_w.push_back(we);
      run_vblank(1'b0, 4);
      set_vcount(0);
      status_read(1'b1, rd);
      check_eq("status_after_abort", rd, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
